pwm_signmag: RTL
================

Name: pwm_signmag

Overview:
- Sign-magnitude H-bridge PWM generator. It sits directly downstream of the one-clock val/sign delay stage in the anspwm datapath.
- It samples a 16-bit magnitude and a sign bit once per PWM frame. It drives a positive-side or negative-side output with the matching duty.
- A dead-time interval is inserted on every direction change. Frame boundaries are exported to upstream stages.

Parameters:
- PERIOD, 1000: clocks per PWM frame; frame counter runs 0..PERIOD-1; range 2..65535.
- DEAD, 4: dead-time length in clocks on a direction change; range 1..PERIOD-1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous and active-low.
- enable  input  1  run control; low = outputs off, counter parked.
- val_in  input  16  unsigned duty magnitude in clocks.
- sign_in  input  1  direction; 0 = pwm_p side, 1 = pwm_n side.
- pwm_p  output  1  positive bridge drive, registered.
- pwm_n  output  1  negative bridge drive, registered.
- frame_start  output  1  one-clock pulse in the first cycle of each frame.
- sat  output  1  high for a frame whose sampled val_in exceeded PERIOD.

Behaviour:
- Reset (rst_n low, asynchronous): all of the following are cleared immediately, independent of clk:
  - cnt=0, duty=0, dsign=0, prev_sign=0
  - state=DISABLED
  - pwm_p=0, pwm_n=0, frame_start=0, sat=0
- Reset mid-frame: outputs drop within the same cycle. Operation restarts from DISABLED on release.
- States: DISABLED, DEAD, RUN.
- DISABLED:
  - cnt held at 0; pwm_p=pwm_n=0; frame_start=0.
  - Each clk: duty=min(val_in,PERIOD), dsign=sign_in, sat=(val_in>PERIOD).
  - enable=1 -> DEAD. The first frame after enable always carries dead time.
- Frame counter (DEAD/RUN): cnt increments each clk and wraps PERIOD-1 -> 0.
- frame_start is high exactly in the cycles where cnt==0 while not DISABLED. This includes the first cycle after leaving DISABLED.
- Sampling at the frame boundary:
  - On the clk where cnt==PERIOD-1, latch prev_sign=dsign, duty=min(val_in,PERIOD), dsign=sign_in, and sat=(val_in>PERIOD).
  - Changes to val_in/sign_in at any other point in a frame have no effect.
  - The upstream delay stage output must be stable on that edge.
- Transition at the boundary: the new frame enters DEAD if the new dsign!=prev_sign, else RUN.
- DEAD:
  - Both outputs low while cnt<DEAD.
  - On the clk where cnt==DEAD-1 -> RUN, unless the frame ends first (not possible given the DEAD range).
- Output rule: in the cycle where cnt==k, the active side (pwm_p if dsign=0, pwm_n if dsign=1) is 1 iff k<duty and not (state==DEAD). The inactive side is 0.
  - Outputs are register-driven (decode the next cnt/state), so they are glitch-free.
- Dead-time effect: the high time of a DEAD frame is max(duty-DEAD,0) clocks.
- Duty extremes:
  - duty=0 gives an always-low output.
  - duty=PERIOD in a RUN frame gives an always-high active side.
  - Consecutive full frames with the same sign give a continuous high across the wrap.
- enable low in DEAD/RUN: the next clk enters DISABLED, cnt=0, both outputs 0. The partial frame is abandoned.
- Invariant: pwm_p and pwm_n are never simultaneously 1, in any cycle, including across reset and enable edges.
- Arithmetic: cnt is 16 bits. Compare val_in>PERIOD in 17 bits; no wrap-around on saturation.

Test Plan:
- Reset mid-frame: drop rst_n at cnt=500 with pwm_p=1 -> pwm_p=0 immediately; after release with enable=1, frame_start pulses on the first enabled clk.
- Steady positive duty: val_in=250, sign_in=0, enable held -> first frame pwm_p high for cnt 4..249 (dead); following frames pwm_p high cnt 0..249, pwm_n=0, frame_start every 1000 clks.
- Direction change: frame N sign=0 val=300, frame N+1 sign=1 val=300 -> N+1: both low cnt 0..3, pwm_n high cnt 4..299; never both high.
- Saturation/extremes: val_in=2000 -> sat=1, duty 1000, pwm_p continuously high across wrap in RUN frames; val_in=0 -> both low, sat=0.
- Mid-frame update ignored: change val_in 250->600 at cnt=100 -> current frame still ends high at cnt=249; next frame uses 600.
- Enable drop: deassert enable at cnt=50, duty 250 -> next clk pwm_p=0, frame_start stays 0; re-enable -> DEAD frame, frame_start pulse on first enabled clk.

Source files
------------

// File: rtl/pwm_signmag.sv
// Sign-magnitude H-bridge PWM: one duty/sign sample per frame, dead time on direction change.
// Outputs registered from next-state decode; no backpressure (free-running frame counter).
module pwm_signmag #(
  parameter int unsigned PERIOD = 1000,
  parameter int unsigned DEAD   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] val_in,
  input  logic        sign_in,
  output logic        pwm_p,
  output logic        pwm_n,
  output logic        frame_start,
  output logic        sat
);

  typedef enum logic [1:0] {
    S_DISABLED = 2'd0,
    S_DEAD     = 2'd1,
    S_RUN      = 2'd2
  } state_t;

  localparam logic [16:0] PERIOD17 = 17'(PERIOD);
  localparam logic [15:0] PERIOD16 = 16'(PERIOD);
  localparam logic [15:0] CNT_LAST = 16'(PERIOD - 1);
  localparam logic [15:0] DEAD_END = 16'(DEAD - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] duty_q, duty_d;
  logic        dsign_q, dsign_d;
  logic        prev_sign_q, prev_sign_d;
  logic        sat_q, sat_d;
  logic        pwm_p_q, pwm_p_d;
  logic        pwm_n_q, pwm_n_d;
  logic        fs_q, fs_d;

  logic        sat_now;
  logic [15:0] duty_now;
  logic        active;

  // Saturation compare is done in 17 bits so large magnitudes never wrap.
  assign sat_now  = {1'b0, val_in} > PERIOD17;
  assign duty_now = sat_now ? PERIOD16 : val_in;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    duty_d      = duty_q;
    dsign_d     = dsign_q;
    prev_sign_d = prev_sign_q;
    sat_d       = sat_q;
    case (state_q)
      S_DISABLED: begin
        cnt_d   = 16'd0;
        duty_d  = duty_now;
        dsign_d = sign_in;
        sat_d   = sat_now;
        if (enable) state_d = S_DEAD;
      end
      default: begin
        if (!enable) begin
          state_d = S_DISABLED;
          cnt_d   = 16'd0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d       = 16'd0;
          prev_sign_d = dsign_q;
          duty_d      = duty_now;
          dsign_d     = sign_in;
          sat_d       = sat_now;
          state_d     = (sign_in != dsign_q) ? S_DEAD : S_RUN;
        end else begin
          cnt_d = cnt_q + 16'd1;
          if (state_q == S_DEAD && cnt_q == DEAD_END) state_d = S_RUN;
        end
      end
    endcase

    // Decode the next cycle's counter/state so the drive pins come straight from flops.
    active  = (state_d == S_RUN) && (cnt_d < duty_d);
    pwm_p_d = active && !dsign_d;
    pwm_n_d = active && dsign_d;
    fs_d    = (state_d != S_DISABLED) && (cnt_d == 16'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_DISABLED;
      cnt_q       <= 16'd0;
      duty_q      <= 16'd0;
      dsign_q     <= 1'b0;
      prev_sign_q <= 1'b0;
      sat_q       <= 1'b0;
      pwm_p_q     <= 1'b0;
      pwm_n_q     <= 1'b0;
      fs_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      duty_q      <= duty_d;
      dsign_q     <= dsign_d;
      prev_sign_q <= prev_sign_d;
      sat_q       <= sat_d;
      pwm_p_q     <= pwm_p_d;
      pwm_n_q     <= pwm_n_d;
      fs_q        <= fs_d;
    end
  end

  assign pwm_p       = pwm_p_q;
  assign pwm_n       = pwm_n_q;
  assign frame_start = fs_q;
  assign sat         = sat_q;

endmodule
